// File: rtl/writeback_arbiter.sv
// Register-file write-port producer: merges ALU results (buffered in a small FIFO)
// and load results into one registered write per cycle, with bypass to decode.
module writeback_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [ADDR_W-1:0]             alu_rd,
    input  logic [DATA_W-1:0]             alu_data,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [ADDR_W-1:0]             mem_rd,
    input  logic [DATA_W-1:0]             mem_data,
    output logic [ADDR_W-1:0]             rd,
    output logic [DATA_W-1:0]             write_data,
    output logic                          reg_write,
    input  logic [ADDR_W-1:0]             rs1,
    input  logic [ADDR_W-1:0]             rs2,
    output logic                          fwd1_hit,
    output logic [DATA_W-1:0]             fwd1_data,
    output logic                          fwd2_hit,
    output logic [DATA_W-1:0]             fwd2_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fifo_rd_q   [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_rd_d   [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              reg_write_q, reg_write_d;

    logic pop;
    logic push;
    logic mem_take;

    always_comb begin
        pop       = (count_q != '0);
        alu_ready = (count_q < CNT_W'(FIFO_DEPTH)) || pop;
        // Loads wait behind every older ALU result so WAW order is kept.
        mem_ready = (count_q == '0);
        push      = alu_valid && alu_ready;
        mem_take  = mem_valid && mem_ready;

        fifo_rd_d    = fifo_rd_q;
        fifo_data_d  = fifo_data_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        rd_d         = rd_q;
        write_data_d = write_data_q;
        reg_write_d  = 1'b0;

        if (push) begin
            fifo_rd_d[tail_q]   = alu_rd;
            fifo_data_d[tail_q] = alu_data;
            tail_d              = tail_q + PTR_W'(1);
        end

        if (pop) begin
            rd_d         = fifo_rd_q[head_q];
            write_data_d = fifo_data_q[head_q];
            reg_write_d  = (fifo_rd_q[head_q] != '0);
            head_d       = head_q + PTR_W'(1);
        end else if (mem_take) begin
            rd_d         = mem_rd;
            write_data_d = mem_data;
            reg_write_d  = (mem_rd != '0);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_rd_q    <= '{default: '0};
            fifo_data_q  <= '{default: '0};
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            rd_q         <= '0;
            write_data_q <= '0;
            reg_write_q  <= 1'b0;
        end else begin
            fifo_rd_q    <= fifo_rd_d;
            fifo_data_q  <= fifo_data_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            rd_q         <= rd_d;
            write_data_q <= write_data_d;
            reg_write_q  <= reg_write_d;
        end
    end

    // Scan oldest to youngest so the tail-most FIFO match overrides the output stage.
    logic [PTR_W-1:0] idx;

    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        idx       = head_q;

        if (reg_write_q && (rs1 != '0) && (rd_q == rs1)) begin
            fwd1_hit  = 1'b1;
            fwd1_data = write_data_q;
        end
        if (reg_write_q && (rs2 != '0) && (rd_q == rs2)) begin
            fwd2_hit  = 1'b1;
            fwd2_data = write_data_q;
        end

        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if ((rs1 != '0) && (fifo_rd_q[idx] == rs1)) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = fifo_data_q[idx];
                end
                if ((rs2 != '0) && (fifo_rd_q[idx] == rs2)) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = fifo_data_q[idx];
                end
            end
        end
    end

    assign rd         = rd_q;
    assign write_data = write_data_q;
    assign reg_write  = reg_write_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: issued results queue their expected writes,
// a monitor checks each register-file write against that queue in order.
module tb_writeback_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic        reg_write;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        fwd1_hit;
    logic [31:0] fwd1_data;
    logic        fwd2_hit;
    logic [31:0] fwd2_data;
    logic [2:0]  fifo_count;

    writeback_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .rd(rd), .write_data(write_data), .reg_write(reg_write),
        .rs1(rs1), .rs2(rs2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .fifo_count(fifo_count)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  errors = 0;
    int  checks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every register-file write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && reg_write) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: actual rd=%0d data=%0h expected no write", rd, write_data);
            end else begin
                e = exp_q.pop_front();
                if (rd !== e.rd || write_data !== e.data) begin
                    errors++;
                    $display("FAIL write_order: actual rd=%0d data=%0h expected rd=%0d data=%0h",
                             rd, write_data, e.rd, e.data);
                end
            end
        end
    end

    task automatic alu_send(input logic [4:0] r, input logic [31:0] d, output int waits);
        if (r != 5'd0) exp_q.push_back('{r, d});
        alu_valid = 1'b1;
        alu_rd    = r;
        alu_data  = d;
        waits     = 0;
        forever begin
            @(negedge clk);
            if (alu_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            waits++;
            if (waits > 20) begin
                checks++;
                errors++;
                $display("FAIL alu_timeout: actual no accept expected accept within 20 cycles");
                break;
            end
        end
        alu_valid = 1'b0;
    endtask

    task automatic mem_send(input logic [4:0] r, input logic [31:0] d, output int waits);
        if (r != 5'd0) exp_q.push_back('{r, d});
        mem_valid = 1'b1;
        mem_rd    = r;
        mem_data  = d;
        waits     = 0;
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            waits++;
            if (waits > 20) begin
                checks++;
                errors++;
                $display("FAIL mem_timeout: actual no accept expected accept within 20 cycles");
                break;
            end
        end
        mem_valid = 1'b0;
    endtask

    initial begin
        int w;
        rst       = 1'b1;
        alu_valid = 1'b1;
        alu_rd    = 5'd1;
        alu_data  = 32'h5;
        mem_valid = 1'b0;
        mem_rd    = '0;
        mem_data  = '0;
        rs1       = '0;
        rs2       = '0;

        // Reset held with a pending ALU result.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_reg_write", reg_write, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_rd", rd, 0);
        chk("rst_write_data", write_data, 0);
        exp_q.push_back('{5'd1, 32'h5});
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("release_push_count", fifo_count, 1);
        alu_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("release_write_rd", rd, 1);
        @(posedge clk);
        #1;

        // Two back-to-back ALU results.
        alu_send(5'd3, 32'h11, w);
        alu_send(5'd4, 32'h22, w);
        chk("pair_first_rd", rd, 3);
        chk("pair_first_data", write_data, 32'h11);
        chk("pair_first_we", reg_write, 1);
        @(posedge clk);
        #1;
        chk("pair_second_rd", rd, 4);
        chk("pair_second_data", write_data, 32'h22);
        chk("pair_drained_count", fifo_count, 0);
        @(posedge clk);
        #1;
        chk("pair_idle_we", reg_write, 0);

        // Load to the same register waits behind the older ALU result.
        alu_send(5'd5, 32'hAA, w);
        chk("waw_mem_ready_blocked", mem_ready, 0);
        chk("waw_count", fifo_count, 1);
        mem_send(5'd5, 32'hBB, w);
        chk("waw_mem_waits", w, 1);
        chk("waw_final_rd", rd, 5);
        chk("waw_final_data", write_data, 32'hBB);
        chk("waw_final_we", reg_write, 1);
        @(posedge clk);
        #1;

        // Six ALU results back to back while a load is held off.
        alu_send(5'd11, 32'h100, w);
        chk("burst_wait_0", w, 0);
        mem_valid = 1'b1;
        mem_rd    = 5'd20;
        mem_data  = 32'h200;
        for (int i = 1; i < 6; i++) begin
            alu_send(5'(11 + i), 32'h100 + 32'(i), w);
            chk("burst_wait", w, 0);
            chk("burst_mem_blocked", mem_ready, 0);
            chk("burst_count", fifo_count, 1);
        end
        mem_send(5'd20, 32'h200, w);
        chk("burst_load_waits", w, 1);
        chk("burst_load_rd", rd, 20);
        chk("burst_load_data", write_data, 32'h200);
        @(posedge clk);
        #1;

        // Forwarding: FIFO entry is younger than the output stage.
        alu_send(5'd7, 32'h1, w);
        alu_send(5'd7, 32'h2, w);
        rs1 = 5'd7;
        rs2 = 5'd0;
        #1;
        chk("fwd1_hit", fwd1_hit, 1);
        chk("fwd1_youngest", fwd1_data, 32'h2);
        chk("fwd2_hit_x0", fwd2_hit, 0);
        chk("fwd2_data_x0", fwd2_data, 0);
        rs2 = 5'd7;
        @(posedge clk);
        #1;
        chk("fwd_outstage_data", fwd2_data, 32'h2);
        chk("fwd_outstage_hit", fwd2_hit, 1);
        @(posedge clk);
        #1;
        chk("fwd_none_hit", fwd1_hit, 0);
        chk("fwd_none_data", fwd1_data, 0);

        // x0 result is consumed but never written or forwarded.
        alu_send(5'd0, 32'hFFFF, w);
        rs1 = 5'd0;
        #1;
        chk("x0_no_fwd", fwd1_hit, 0);
        @(posedge clk);
        #1;
        chk("x0_no_write", reg_write, 0);
        chk("x0_consumed_data", write_data, 32'hFFFF);
        chk("x0_count", fifo_count, 0);

        // Reset in the middle of a burst.
        alu_send(5'd9, 32'h90, w);
        alu_send(5'd10, 32'hA0, w);
        rs1 = 5'd10;
        #1;
        chk("pre_rst_fwd_hit", fwd1_hit, 1);
        chk("pre_rst_fwd_data", fwd1_data, 32'hA0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_we", reg_write, 0);
        chk("mid_rst_rd", rd, 0);
        chk("mid_rst_data", write_data, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_fwd_hit", fwd1_hit, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("post_rst_idle_we", reg_write, 0);
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
